// File: rtl/addsub_arbiter.sv
// ----------------------------------------------------------------------------
// addsub_arbiter
//
// Shares one 8-bit add/subtract unit between two requesters. An operation is
// accepted from one requester in IDLE, its operands are registered, the shared
// unit evaluates them during EXEC, and the result plus status flags are held
// in RESP on a single response channel tagged with the requester ID until the
// consumer takes it. One operation is in flight at a time.
//
// Parameters:
//   ROUND_ROBIN  1 = alternate grants on a tie, 0 = requester 0 always wins.
//
// Ports:
//   clk                    clock, all state on the rising edge
//   rst_n                  asynchronous active-low reset
//   req0_valid/req1_valid  requester has an operation
//   req0_ready/req1_ready  operation accepted this cycle (IDLE only)
//   req0_a/b, req1_a/b     8-bit operands
//   req0_sel/req1_sel      0 = A+B, 1 = A-B
//   rsp_valid              response available (RESP state)
//   rsp_ready              consumer accepts the response
//   rsp_id                 requester that issued the operation
//   rsp_y                  8-bit result
//   rsp_cout               carry out; for subtract 1 = no borrow
//   rsp_zero, rsp_neg      result is zero / result bit 7
//   rsp_ovf                signed overflow
//   busy                   controller is in EXEC or RESP
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// addsub_8bit
//
// Combinational 8-bit adder/subtractor. Subtraction is A + ~B + 1, so cout is
// the true adder carry and reads 1 when no borrow occurred.
//
// Ports:
//   a, b   8-bit operands
//   sel    0 = add, 1 = subtract
//   y      8-bit result (wraps modulo 256)
//   cout   carry out of bit 7
// ----------------------------------------------------------------------------
module addsub_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sel,
    output logic [7:0] y,
    output logic       cout
);

    logic [8:0] sum;
    logic [7:0] b_eff;

    // Inverting B and injecting sel as the carry-in turns the adder into a
    // two's-complement subtractor.
    always_comb begin
        b_eff = b ^ {8{sel}};
        sum   = {1'b0, a} + {1'b0, b_eff} + {8'b0, sel};
        y     = sum[7:0];
        cout  = sum[8];
    end

endmodule

module addsub_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic       rsp_cout,
    output logic       rsp_zero,
    output logic       rsp_neg,
    output logic       rsp_ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       op_sel_q, op_sel_d;
    logic       op_id_q, op_id_d;

    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_y_q, rsp_y_d;
    logic       rsp_cout_q, rsp_cout_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_neg_q, rsp_neg_d;
    logic       rsp_ovf_q, rsp_ovf_d;

    logic       any_valid;
    logic       grant_id;
    logic       accept;

    logic [7:0] unit_y;
    logic       unit_cout;
    logic       unit_ovf;

    // The shared unit always sees the operand registers; its output only
    // matters during EXEC when the response registers load it.
    addsub_8bit u_addsub (
        .a    (op_a_q),
        .b    (op_b_q),
        .sel  (op_sel_q),
        .y    (unit_y),
        .cout (unit_cout)
    );

    // Grant selection. On a tie, round-robin picks the requester that did not
    // win last time; fixed priority always picks requester 0. rst_n gates the
    // accept so neither ready can show while reset is asserted.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            if (ROUND_ROBIN != 0) begin
                grant_id = ~last_grant_q;
            end else begin
                grant_id = 1'b0;
            end
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        accept = rst_n && (state_q == ST_IDLE) && any_valid;
    end

    // Signed overflow: an add overflows when like-signed operands produce a
    // result of the other sign; a subtract when unlike-signed operands do.
    always_comb begin
        unit_ovf = 1'b0;
        if (op_sel_q) begin
            unit_ovf = (op_a_q[7] != op_b_q[7]) && (unit_y[7] != op_a_q[7]);
        end else begin
            unit_ovf = (op_a_q[7] == op_b_q[7]) && (unit_y[7] != op_a_q[7]);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept and response capture at the end of EXEC.
    // Outside those moments every register holds, which keeps rsp_* stable
    // for as long as the consumer back-pressures.
    always_comb begin
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        op_id_d      = op_id_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_ovf_d    = rsp_ovf_q;

        if (accept) begin
            last_grant_d = grant_id;
            op_id_d      = grant_id;
            if (grant_id) begin
                op_a_d   = req1_a;
                op_b_d   = req1_b;
                op_sel_d = req1_sel;
            end else begin
                op_a_d   = req0_a;
                op_b_d   = req0_b;
                op_sel_d = req0_sel;
            end
        end

        if (state_q == ST_EXEC) begin
            rsp_id_d   = op_id_q;
            rsp_y_d    = unit_y;
            rsp_cout_d = unit_cout;
            rsp_zero_d = (unit_y == 8'h00);
            rsp_neg_d  = unit_y[7];
            rsp_ovf_d  = unit_ovf;
        end
    end

    // State register and all datapath flops. last_grant resets to 1 so the
    // first tie after reset goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= 8'h00;
            op_b_q       <= 8'h00;
            op_sel_q     <= 1'b0;
            op_id_q      <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= 8'h00;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            op_id_q      <= op_id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    // Outputs. Ready is combinational and only ever high for the granted
    // requester while in IDLE.
    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        busy       = (state_q != ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        rsp_id     = rsp_id_q;
        rsp_y      = rsp_y_q;
        rsp_cout   = rsp_cout_q;
        rsp_zero   = rsp_zero_q;
        rsp_neg    = rsp_neg_q;
        rsp_ovf    = rsp_ovf_q;
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// ----------------------------------------------------------------------------
// tb_addsub_arbiter
//
// Directed bench for addsub_arbiter. Two instances share all inputs: dut_rr
// uses round-robin arbitration, dut_fp fixed priority. Only the contention
// phase looks at dut_fp; elsewhere they behave identically.
// ----------------------------------------------------------------------------
module tb_addsub_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_sel, req1_sel;
    logic       rsp_ready;

    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_cout, rsp_zero, rsp_neg, rsp_ovf, busy;
    logic [7:0] rsp_y;

    logic       fp_req0_ready, fp_req1_ready;
    logic       fp_rsp_valid, fp_rsp_id, fp_rsp_cout, fp_rsp_zero, fp_rsp_neg;
    logic       fp_rsp_ovf, fp_busy;
    logic [7:0] fp_rsp_y;

    int checks_total;
    int checks_passed;

    addsub_arbiter #(.ROUND_ROBIN(1)) dut_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    addsub_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (fp_req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (fp_req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (fp_rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (fp_rsp_id),
        .rsp_y      (fp_rsp_y),
        .rsp_cout   (fp_rsp_cout),
        .rsp_zero   (fp_rsp_zero),
        .rsp_neg    (fp_rsp_neg),
        .rsp_ovf    (fp_rsp_ovf),
        .busy       (fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic id, input logic [7:0] a,
                                 input logic [7:0] b, input logic sel);
        if (id) begin
            req1_valid = 1'b1;
            req1_a     = a;
            req1_b     = b;
            req1_sel   = sel;
        end else begin
            req0_valid = 1'b1;
            req0_a     = a;
            req0_b     = b;
            req0_sel   = sel;
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) until the given requester sees ready. Returns with the
    // accept edge being the next rising edge.
    task automatic waitReady(input logic id, output logic got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((id && req1_ready) || (!id && req0_ready)) begin
                got = 1'b1;
                break;
            end
            nextCycle();
        end
    endtask

    task automatic runOp(input string tag, input logic id, input logic [7:0] a,
                         input logic [7:0] b, input logic sel,
                         input logic [7:0] exp_y, input logic [3:0] exp_flags);
        logic got;
        applyStimulus(id, a, b, sel);
        rsp_ready = 1'b1;
        waitReady(id, got);
        checkOutput({tag, "_accept"}, {31'b0, got}, 32'd1);
        if (got) begin
            nextCycle();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            checkOutput({tag, "_exec"}, {30'b0, rsp_valid, busy}, 32'b01);
            nextCycle();
            checkOutput({tag, "_valid_id"}, {30'b0, rsp_valid, rsp_id},
                        {30'b0, 1'b1, id});
            checkOutput({tag, "_y"}, {24'b0, rsp_y}, {24'b0, exp_y});
            checkOutput({tag, "_flags"},
                        {28'b0, rsp_cout, rsp_zero, rsp_neg, rsp_ovf},
                        {28'b0, exp_flags});
            nextCycle();
            checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
        end else begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    int   rr_grant[8];
    int   rr_cyc[8];
    int   fp_grant[8];
    int   rr_n, fp_n, both_ready;
    logic got;
    logic saw_valid;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = 8'h00; req0_b = 8'h00; req0_sel = 1'b0;
        req1_a = 8'h00; req1_b = 8'h00; req1_sel = 1'b0;
        rsp_ready  = 1'b0;

        // Reset state, with both requesters already asserting valid.
        repeat (2) @(posedge clk);
        #2;
        applyStimulus(0, 8'd1, 8'd2, 1'b0);
        applyStimulus(1, 8'd3, 8'd4, 1'b0);
        rsp_ready = 1'b1;
        #1;
        checkOutput("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        checkOutput("rst_busy_valid", {30'b0, busy, rsp_valid}, 32'd0);
        checkOutput("rst_rsp", {22'b0, rsp_id, rsp_y, rsp_cout, rsp_zero},
                    32'd0);
        checkOutput("rst_neg_ovf", {30'b0, rsp_neg, rsp_ovf}, 32'd0);

        // Contention from reset: both valid continuously, rsp_ready high.
        rst_n      = 1'b1;
        rr_n       = 0;
        fp_n       = 0;
        both_ready = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                if (rr_n < 8) begin
                    rr_grant[rr_n] = req1_ready ? 1 : 0;
                    rr_cyc[rr_n]   = cyc;
                end
                rr_n++;
            end
            if (fp_req0_ready || fp_req1_ready) begin
                if (fp_n < 8) fp_grant[fp_n] = fp_req1_ready ? 1 : 0;
                fp_n++;
            end
            if (req0_ready && req1_ready) both_ready++;
            if (fp_req0_ready && fp_req1_ready) both_ready++;
            nextCycle();
        end
        checkOutput("rr_accepts", rr_n, 32'd5);
        checkOutput("fp_accepts", fp_n, 32'd5);
        checkOutput("both_ready", both_ready, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_grant%0d", i), rr_grant[i], i % 2);
            checkOutput($sformatf("fp_grant%0d", i), fp_grant[i], 32'd0);
            checkOutput($sformatf("rr_spacing%0d", i),
                        rr_cyc[i+1] - rr_cyc[i], 32'd3);
        end

        // Clean restart before the directed operations.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Flags order: {cout, zero, neg, ovf}
        runOp("add_100_20", 1'b0, 8'd100, 8'd20, 1'b0, 8'd120, 4'b0000);
        runOp("sub_5_5",    1'b1, 8'd5,   8'd5,  1'b1, 8'h00,  4'b1100);
        runOp("sub_80_1",   1'b0, 8'h80,  8'h01, 1'b1, 8'h7F,  4'b1001);
        runOp("add_127_1",  1'b1, 8'd127, 8'd1,  1'b0, 8'h80,  4'b0011);
        runOp("add_ff_1",   1'b0, 8'hFF,  8'h01, 1'b0, 8'h00,  4'b1100);
        runOp("sub_20_100", 1'b1, 8'd20,  8'd100, 1'b1, 8'hB0, 4'b0010);

        // Back-pressure: response held while req1 waits.
        applyStimulus(0, 8'd50, 8'd60, 1'b0);
        rsp_ready = 1'b0;
        waitReady(0, got);
        checkOutput("bp_accept0", {31'b0, got}, 32'd1);
        nextCycle();
        req0_valid = 1'b0;
        applyStimulus(1, 8'd200, 8'd100, 1'b1);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_hold%0d", i),
                        {22'b0, rsp_valid, rsp_id, rsp_y},
                        {22'b0, 1'b1, 1'b0, 8'd110});
            checkOutput($sformatf("bp_req1_ready%0d", i),
                        {31'b0, req1_ready}, 32'd0);
            nextCycle();
        end
        rsp_ready = 1'b1;
        nextCycle();
        #1;
        checkOutput("bp_release", {30'b0, busy, req1_ready}, 32'b01);
        nextCycle();
        req1_valid = 1'b0;
        checkOutput("bp_req1_exec", {31'b0, busy}, 32'd1);
        nextCycle();
        checkOutput("bp_req1_rsp",
                    {18'b0, rsp_valid, rsp_id, rsp_y, rsp_cout, rsp_zero,
                     rsp_neg, rsp_ovf},
                    {18'b0, 1'b1, 1'b1, 8'h64, 4'b1001});
        nextCycle();

        // Reset in EXEC discards the operation; last_grant returns to 1.
        applyStimulus(0, 8'd10, 8'd20, 1'b0);
        waitReady(0, got);
        checkOutput("mid_accept", {31'b0, got}, 32'd1);
        nextCycle();
        req0_valid = 1'b0;
        checkOutput("mid_in_exec", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_outputs",
                    {16'b0, busy, rsp_valid, rsp_id, rsp_y, rsp_cout,
                     rsp_zero, rsp_neg, rsp_ovf},
                    32'd0);
        checkOutput("mid_rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rsp_valid || busy) saw_valid = 1'b1;
            nextCycle();
        end
        checkOutput("mid_no_rsp", {31'b0, saw_valid}, 32'd0);
        applyStimulus(0, 8'd7, 8'd9, 1'b0);
        applyStimulus(1, 8'd1, 8'd1, 1'b1);
        #1;
        checkOutput("mid_first_tie", {30'b0, req0_ready, req1_ready}, 32'b10);
        nextCycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        nextCycle();
        checkOutput("mid_tie_rsp", {22'b0, rsp_valid, rsp_id, rsp_y},
                    {22'b0, 1'b1, 1'b0, 8'd16});
        nextCycle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Sequencing and arbitration controller that shares a single `addsub_8bit` add/subtract unit between two requesters. It accepts operations over per-requester valid/ready ports and grants the unit round-robin (or fixed priority). It registers operands, drives the shared unit, and returns the registered result with status flags on one shared response channel tagged with the requester ID. It sits between the custom-ALU front end and the adder datapath; `addsub_8bit` is instantiated inside.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1: 1 = round-robin grant; 0 = fixed priority, requester 0 always wins.

Ports:
- `clk`  input  1  single clock; all state on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `req0_valid`  input  1  requester 0 has an operation.
- `req0_ready`  output  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  input  8 each  requester 0 operands.
- `req0_sel`  input  1  requester 0 operation: 0 = A+B, 1 = A−B.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as requester 0, for requester 1.
- `rsp_valid`  output  1  response available.
- `rsp_ready`  input  1  consumer accepts the response.
- `rsp_id`  output  1  requester that issued the operation.
- `rsp_y`  output  8  result.
- `rsp_cout`  output  1  adder carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- `rsp_zero`  output  1  `rsp_y` == 0.
- `rsp_neg`  output  1  `rsp_y[7]`.
- `rsp_ovf`  output  1  signed overflow.
- `busy`  output  1  state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `reqN_valid` is high, pick a grant.
  - Assert `reqN_ready` for the granted requester only. It is combinational and high only in IDLE.
  - Capture a, b, sel and ID into operand registers. Go to EXEC.
  - With no valid request, stay in IDLE.
- **Grant rule**
  - Only one requester valid: that requester wins.
  - Both valid and `ROUND_ROBIN`=1: grant the requester not granted last. The `last_grant` register resets to 1, so requester 0 wins the first tie.
  - Both valid and `ROUND_ROBIN`=0: requester 0 wins.
  - `last_grant` updates on every accept.
- **EXEC**
  - Operand registers drive `addsub_8bit` (A, B, Sel).
  - At end of cycle, register Y, Cout and the flags into the response registers. Go to RESP.
- **RESP**
  - `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`=1.
  - On a handshake (`rsp_valid`=1 and `rsp_ready`=1): go to IDLE.
  - No request is accepted while in EXEC or RESP.
- **Flags** (computed from registered A, B, sel and Y)
  - zero = (Y == 8'h00).
  - neg = Y[7].
  - ovf for add: (A[7] == B[7]) and (Y[7] != A[7]).
  - ovf for sub: (A[7] != B[7]) and (Y[7] != A[7]).
  - cout: taken directly from the unit.
- **Widths:** 8-bit modular arithmetic, wrap-around with no saturation.
- **Requester rule:** a requester must hold `valid`, a, b and sel stable until it sees `ready`. A `valid` drop before `ready` withdraws the request without error.

## Timing
- **Reset:** asynchronous `rst_n`=0 forces:
  - state IDLE, `last_grant`=1;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_cout`=0, `rsp_zero`=0, `rsp_neg`=0, `rsp_ovf`=0;
  - `busy`=0, both `reqN_ready`=0.
- **Reset mid-operation** (EXEC or RESP): the in-flight operation is discarded and no response is produced. Operation resumes at the first rising edge after deassertion.
- **Latency:**
  - Accept in cycle T (IDLE, `ready`=1).
  - Response registered at edge T+2; `rsp_valid`=1 from cycle T+2.
  - Handshake at cycle T+2 → IDLE at T+3 → next accept no earlier than T+3.
  - Peak throughput is 1 operation per 3 cycles.
- **Back-pressure:** `rsp_ready` low holds RESP indefinitely. The unaccepted requester keeps waiting and is served next, per the grant rule.
- **Simultaneous events:**
  - Both valid in IDLE: exactly one `ready` is high.
  - `rsp_ready` high outside RESP: ignored.
- `busy` is 1 in EXEC and RESP.

## Test plan
- **Add, no carry:** req0 a=100, b=20, sel=0 → `rsp_valid` 2 cycles after accept; id=0, y=120, cout=0, zero=0, neg=0, ovf=0.
- **Sub, zero and overflow:**
  - req1 a=5, b=5, sel=1 → id=1, y=0, zero=1, cout=1.
  - a=8'h80, b=1, sel=1 → y=8'h7F, ovf=1, cout=1.
- **Add overflow:** a=127, b=1, sel=0 → y=8'h80, neg=1, ovf=1, cout=0.
  - a=8'hFF, b=1 → y=0, zero=1, cout=1, ovf=0.
- **Contention, round-robin:** both valid continuously from reset, rsp_ready=1 → grants alternate 0,1,0,1 with one accept every 3 cycles.
  - With `ROUND_ROBIN`=0 → grants are 0,0,0.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles in RESP with req1 valid → `rsp_*` stable and `req1_ready`=0 throughout. Raise `rsp_ready` → IDLE next cycle, then req1 accepted.
- **Reset mid-EXEC:** pull `rst_n` low in EXEC → `rsp_valid` never asserts for that operation, all outputs at reset values, `busy`=0. After release, first tie goes to req0.
